quad_encoder_gen: RTL
=====================

# quad_encoder_gen

Multi-channel quadrature encoder emulator: generates A/B quadrature, index (Z) and a position count per channel from clockwise/counter-clockwise motion requests. Each channel has a programmable step-rate divider and wraps modulo a configurable counts-per-revolution. It sits between motion-command logic and any consumer expecting real encoder signals, such as decoders and motor-control test harnesses. It is the parametrised successor of the single-channel, one-step-per-clock encoder.

## Interface
- CHANNELS, 2: number of independent encoder channels (≥1)
- DIV_W, 16: width of each channel's rate divider
- CPR, 400: quadrature counts per revolution; must be a multiple of 4 and ≥4
- POS_W, $clog2(CPR): width of each position count (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; **asynchronous, active-low**
- cw  in  CHANNELS  per-channel clockwise request (level)
- ccw  in  CHANNELS  per-channel counter-clockwise request (level)
- div  in  CHANNELS*DIV_W  per-channel divider; channel i uses bits [i*DIV_W +: DIV_W]; step period = div+1 clocks
- a  out  CHANNELS  quadrature phase A
- b  out  CHANNELS  quadrature phase B
- z  out  CHANNELS  index; high while position == 0
- dir  out  CHANNELS  last step direction: 1 = cw, 0 = ccw
- pos  out  CHANNELS*POS_W  position count; channel i at [i*POS_W +: POS_W]

## Operation
- Channels are fully independent. Per-channel state is the 2-bit phase {a,b}, a DIV_W tick counter, pos, dir, and the previous command {cw,ccw}.
- Motion command per channel:
  - cw=1, ccw=0: clockwise.
  - cw=0, ccw=1: counter-clockwise.
  - 00 or 11: idle. Everything holds and the tick counter clears to 0.
- Tick counter:
  - Increments each clock while a motion command is active.
  - When counter ≥ div, a step occurs and the counter clears to 0. The ≥ test makes a div lowered mid-count take effect on the next clock.
- Command change clears the counter and no step occurs that cycle. A change is any difference between the current and previous {cw,ccw}, including a direct cw↔ccw reversal.
- Clockwise step:
  - {a,b} sequence 00→10→11→01→00.
  - pos+1, with CPR-1 wrapping to 0.
  - dir←1.
- Counter-clockwise step:
  - {a,b} sequence 00→01→11→10→00.
  - pos−1, with 0 wrapping to CPR-1.
  - dir←0.
- Invariant: {a,b} is a function of pos[1:0] (0→00, 1→10, 2→11, 3→01). Because CPR%4==0, z=1 only while {a,b}=00.
- An unreachable phase code recovers to 00 on the next step.

## Timing
- All outputs are registered. Exactly one of a/b toggles per step, and at most one step per channel per clock.
- Reset values: a=0, b=0, pos=0, z=1, dir=0, tick counter=0, previous command=00.
- Reset is asynchronous mid-operation: all state returns to reset values immediately, and the first step after reset release obeys the latency below.
- Latency: a command asserted before edge k (and differing from the previous command) is registered at edge k. The first step appears after edge k+div+1; later steps follow every div+1 clocks.
- div=0 gives one step per clock after the command-registering edge.
- z tracks pos combinationally from registered pos, so it is effectively registered and asserts in the same cycle pos reaches 0.

## Structure
- Shared package quad_pkg holds:
  - the phase encoding constants PH0=2'b00, PH1=2'b10, PH2=2'b11, PH3=2'b01;
  - the command enum CMD_IDLE/CMD_CW/CMD_CCW;
  - the phase-successor and phase-predecessor functions.
- Sub-module quad_encoder_channel implements one channel: divider, phase FSM and position counter. The top level instantiates it CHANNELS times with a generate loop and slices div/pos.
- An elaboration-time check rejects CPR%4≠0 or CPR<4.

## Test plan
- Reset, then hold cw=1 on ch0 with div=0 for 8 clocks -> {a,b} steps 10,11,01,00,… once per clock after the registering edge; pos counts 1..7; dir=1.
- ch1 div=3, ccw=1 from pos=0 -> first step 4 clocks after the registering edge: pos=CPR-1, {a,b}=01, z falls; steps every 4 clocks thereafter.
- cw run to pos=CPR-1, then one more step -> pos=0, {a,b}=00, z=1 for exactly that position.
- cw at div=0, switch directly to ccw -> one idle clock with counter cleared, then pos decrements; cw=ccw=1 -> all outputs hold.
- Assert rst_n=0 mid-run with pos=123 and {a,b}=01 -> outputs immediately 0/0/pos=0/z=1 without waiting for clk; after release, normal latency.
- Both channels run with different commands and divs simultaneously -> no cross-channel interference; per-channel counts match the reference model.

Source files
------------

// File: rtl/quad_pkg.sv
// ============================================================================
// Module   : quad_pkg
// Purpose  : Shared phase encoding, motion command type and phase stepping
//            helpers for the quadrature encoder emulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package quad_pkg;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_CW   = 2'd1,
    CMD_CCW  = 2'd2
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic cw, input logic ccw);
    case ({cw, ccw})
      2'b10:   return CMD_CW;
      2'b01:   return CMD_CCW;
      default: return CMD_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] phase_next(input logic [1:0] ph);
    case (ph)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      PH3:     return PH0;
      default: return PH0;
    endcase
  endfunction

  function automatic logic [1:0] phase_prev(input logic [1:0] ph);
    case (ph)
      PH0:     return PH3;
      PH3:     return PH2;
      PH2:     return PH1;
      PH1:     return PH0;
      default: return PH0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_encoder_channel.sv
// ============================================================================
// Module   : quad_encoder_channel
// Purpose  : One encoder channel: step-rate divider, A/B phase and position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_encoder_channel
  import quad_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CPR   = 400,
  parameter int POS_W = $clog2(CPR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cw,
  input  logic             ccw,
  input  logic [DIV_W-1:0] div,
  output logic             a,
  output logic             b,
  output logic             z,
  output logic             dir,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] c_pos_max = POS_W'(CPR - 1);

  logic [1:0]       r_phase;
  logic [DIV_W-1:0] r_cnt;
  logic [POS_W-1:0] r_pos;
  logic             r_dir;
  logic [1:0]       r_prev_cmd;

  logic [1:0]       w_cmd_raw;
  cmd_e             w_cmd;
  logic             w_cmd_changed;

  assign w_cmd_raw     = {cw, ccw};
  assign w_cmd         = decode_cmd(cw, ccw);
  // 00 -> 11 counts as a change too, so the raw pair is compared, not the enum
  assign w_cmd_changed = (w_cmd_raw != r_prev_cmd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= PH0;
      r_cnt      <= '0;
      r_pos      <= '0;
      r_dir      <= 1'b0;
      r_prev_cmd <= 2'b00;
    end else begin
      r_prev_cmd <= w_cmd_raw;
      if (w_cmd_changed || (w_cmd == CMD_IDLE)) begin
        r_cnt <= '0;
      end else if (r_cnt >= div) begin
        r_cnt <= '0;
        if (w_cmd == CMD_CW) begin
          r_phase <= phase_next(r_phase);
          r_pos   <= (r_pos == c_pos_max) ? '0 : r_pos + 1'b1;
          r_dir   <= 1'b1;
        end else begin
          r_phase <= phase_prev(r_phase);
          r_pos   <= (r_pos == '0) ? c_pos_max : r_pos - 1'b1;
          r_dir   <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign a   = r_phase[1];
  assign b   = r_phase[0];
  assign z   = (r_pos == '0);
  assign dir = r_dir;
  assign pos = r_pos;

endmodule

`default_nettype wire

// File: rtl/quad_encoder_gen.sv
// ============================================================================
// Module   : quad_encoder_gen
// Purpose  : Multi-channel quadrature encoder emulator (A/B/Z plus position).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter  int CHANNELS = 2,
  parameter  int DIV_W    = 16,
  parameter  int CPR      = 400,
  localparam int POS_W    = $clog2(CPR)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       cw,
  input  logic [CHANNELS-1:0]       ccw,
  input  logic [CHANNELS*DIV_W-1:0] div,
  output logic [CHANNELS-1:0]       a,
  output logic [CHANNELS-1:0]       b,
  output logic [CHANNELS-1:0]       z,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS*POS_W-1:0] pos
);

  // Z is only guaranteed to coincide with phase 00 when CPR is a multiple of 4
  if ((CPR % 4 != 0) || (CPR < 4)) begin : g_cpr_check
    $error("quad_encoder_gen: CPR must be a multiple of 4 and at least 4");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    quad_encoder_channel #(
      .DIV_W (DIV_W),
      .CPR   (CPR),
      .POS_W (POS_W)
    ) u_channel (
      .clk   (clk),
      .rst_n (rst_n),
      .cw    (cw[i]),
      .ccw   (ccw[i]),
      .div   (div[i*DIV_W +: DIV_W]),
      .a     (a[i]),
      .b     (b[i]),
      .z     (z[i]),
      .dir   (dir[i]),
      .pos   (pos[i*POS_W +: POS_W])
    );
  end

endmodule

`default_nettype wire
